// File: rtl/axi_stat_pkg.sv
// Shared constants, state types and the byte-strobe merge helper for the
// bridge status AXI4-Lite window.
package axi_stat_pkg;

  localparam logic [11:0] OFS_STAT    = 12'h000;
  localparam logic [11:0] OFS_SCRATCH = 12'h004;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wr_state_t;
  typedef enum logic { R_IDLE, R_DATA } rd_state_t;

  // Merge new write data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_stat_addr_dec.sv
// Address decoder for the status window: classifies an address as the status
// register, the scratch register, or an error. Byte-lane bits [1:0] are ignored.
module axi_stat_addr_dec
  import axi_stat_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'hC0F16000
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit_stat,
  output logic              o_hit_scratch,
  output logic              o_err
);

  logic w_in_window;
  logic w_unused_lsb;

  assign w_in_window   = (i_addr[ADDR_W-1:12] == BASE_ADDR[ADDR_W-1:12]);
  assign o_hit_stat    = w_in_window && (i_addr[11:2] == OFS_STAT[11:2]);
  assign o_hit_scratch = w_in_window && (i_addr[11:2] == OFS_SCRATCH[11:2]);
  assign o_err         = !(o_hit_stat || o_hit_scratch);
  assign w_unused_lsb  = ^i_addr[1:0];

endmodule

// File: rtl/axi_lite_stat_slave.sv
// AXI4-Lite slave for the bridge status window: read-to-clear status register,
// RW scratch register, and one-cycle completion / clear strobes.
module axi_lite_stat_slave
  import axi_stat_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'hC0F16000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [31:0]       stat_rdata,
  output logic              stat_read,
  output logic              wr_done,
  output logic              rd_done
);

  wr_state_t         r_wstate;
  logic              r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [1:0]        r_bresp;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata, r_scratch;
  logic [3:0]        r_wstrb;

  rd_state_t         r_rstate;
  logic              r_arready, r_rvalid;
  logic [1:0]        r_rresp;
  logic [31:0]       r_rdata;

  logic              w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_ar_hs;
  logic [ADDR_W-1:0] w_awaddr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic              w_wr_hit_stat, w_wr_hit_scratch, w_wr_err;
  logic              w_rd_hit_stat, w_rd_hit_scratch, w_rd_err;

  assign w_aw_hs   = s_awvalid && r_awready;
  assign w_w_hs    = s_wvalid && r_wready;
  assign w_aw_have = r_aw_held || w_aw_hs;
  assign w_w_have  = r_w_held || w_w_hs;
  assign w_ar_hs   = s_arvalid && r_arready;

  // The write completes in the cycle the later half arrives, so take that half straight from the bus.
  assign w_awaddr = r_aw_held ? r_awaddr : s_awaddr;
  assign w_wdata  = r_w_held  ? r_wdata  : s_wdata;
  assign w_wstrb  = r_w_held  ? r_wstrb  : s_wstrb;

  axi_stat_addr_dec #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_wr_dec (
    .i_addr        (w_awaddr),
    .o_hit_stat    (w_wr_hit_stat),
    .o_hit_scratch (w_wr_hit_scratch),
    .o_err         (w_wr_err)
  );

  axi_stat_addr_dec #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_rd_dec (
    .i_addr        (s_araddr),
    .o_hit_stat    (w_rd_hit_stat),
    .o_hit_scratch (w_rd_hit_scratch),
    .o_err         (w_rd_err)
  );

  // NOTE: use non-blocking (<=) for every flop so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_scratch <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wready <= 1'b0;
          end
          if (w_aw_have && w_w_have) begin
            if (w_wr_hit_scratch) r_scratch <= apply_wstrb(r_scratch, w_wdata, w_wstrb);
            r_bresp   <= (w_wr_hit_stat || w_wr_err) ? RESP_SLVERR : RESP_OKAY;
            r_bvalid  <= 1'b1;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // NOTE: holding registers are qualified by the held flags, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= s_awaddr;
    if (w_w_hs) begin
      r_wdata <= s_wdata;
      r_wstrb <= s_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_rd_hit_stat    ? stat_rdata :
                         w_rd_hit_scratch ? r_scratch  : '0;
            r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;

  // Strobes mark handshakes in their own cycle; a handshake under reset never completes.
  assign stat_read = !rst && w_ar_hs && w_rd_hit_stat;
  assign wr_done   = !rst && r_bvalid && s_bready;
  assign rd_done   = !rst && r_rvalid && s_rready;

endmodule
